// File: rtl/rll_key_loader.sv
// Chunked key loader for RLL-locked cores: shifts in key chunks, verifies an
// XOR-fold check word, then drives the verified key; sticky lockout on repeated failures.
module rll_key_loader #(
   parameter int KEY_WIDTH   = 32,
   parameter int CHUNK_WIDTH = 8,
   parameter int MAX_FAIL    = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_start,
   input  logic                          chunk_valid,
   input  logic [CHUNK_WIDTH-1:0]        chunk_data,
   output logic                          chunk_ready,
   input  logic                          check_valid,
   input  logic [CHUNK_WIDTH-1:0]        check_data,
   output logic [KEY_WIDTH-1:0]          key_out,
   output logic                          key_armed,
   output logic                          lockout,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_count,
   output logic                          busy
);
   localparam int NCHUNK = KEY_WIDTH / CHUNK_WIDTH;
   localparam int CNTW   = $clog2(NCHUNK + 1);
   localparam int FCW    = $clog2(MAX_FAIL + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_ARMED, S_LOCK} state_t;

   state_t                 state;
   logic [KEY_WIDTH-1:0]   shadow;
   logic [CNTW-1:0]        count;
   logic [CHUNK_WIDTH-1:0] fold;
   logic [FCW-1:0]         fail_inc;

   always_comb begin
      fold = '0;
      for (int i = 0; i < NCHUNK; i++)
         fold = fold ^ shadow[i*CHUNK_WIDTH +: CHUNK_WIDTH];
   end

   assign fail_inc    = fail_count + 1'b1;
   // load_start masks ready so a chunk coincident with a restart is never taken
   assign chunk_ready = (state == S_LOAD) && (count < CNTW'(NCHUNK)) && !load_start;
   assign busy        = (state == S_LOAD) || (state == S_WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         shadow     <= '0;
         count      <= '0;
         key_out    <= '0;
         key_armed  <= 1'b0;
         lockout    <= 1'b0;
         fail_count <= '0;
      end else begin
         case (state)
            S_IDLE, S_ARMED: begin
               if (load_start) begin
                  shadow    <= '0;
                  count     <= '0;
                  key_out   <= '0;
                  key_armed <= 1'b0;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (load_start) begin
                  shadow <= '0;
                  count  <= '0;
               end else if (chunk_valid && chunk_ready) begin
                  shadow <= {shadow[KEY_WIDTH-CHUNK_WIDTH-1:0], chunk_data};
                  count  <= count + 1'b1;
                  if (count == CNTW'(NCHUNK - 1))
                     state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (load_start) begin
                  shadow <= '0;
                  count  <= '0;
                  state  <= S_LOAD;
               end else if (check_valid) begin
                  if (fold == check_data) begin
                     key_out    <= shadow;
                     key_armed  <= 1'b1;
                     fail_count <= '0;
                     state      <= S_ARMED;
                  end else begin
                     shadow     <= '0;
                     fail_count <= fail_inc;
                     if (fail_inc == FCW'(MAX_FAIL)) begin
                        lockout <= 1'b1;
                        key_out <= '0;
                        state   <= S_LOCK;
                     end else begin
                        state   <= S_IDLE;
                     end
                  end
               end
            end
            S_LOCK: begin
               key_out   <= '0;
               key_armed <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rll_key_loader.sv
// Scoreboard bench for rll_key_loader: default build plus a MAX_FAIL=1 build.
module tb_rll_key_loader;
   logic        clk = 1'b0;
   logic        rst_n, load_start, chunk_valid, check_valid;
   logic [7:0]  chunk_data, check_data;
   logic        chunk_ready, key_armed, lockout, busy;
   logic [31:0] key_out;
   logic [1:0]  fail_count;

   logic        rst_n1, ls1, cv1, kv1, cr1, armed1, lock1, busy1;
   logic [7:0]  cd1, kd1;
   logic [31:0] key1;
   logic [0:0]  fc1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] key;
      logic        armed;
      logic [1:0]  fail;
      logic        lock;
   } exp_t;
   exp_t sb[$];

   logic [31:0] m_shadow;
   logic [1:0]  m_fail;
   logic        m_lock;

   always #5 clk = ~clk;

   rll_key_loader dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start),
      .chunk_valid(chunk_valid), .chunk_data(chunk_data), .chunk_ready(chunk_ready),
      .check_valid(check_valid), .check_data(check_data),
      .key_out(key_out), .key_armed(key_armed), .lockout(lockout),
      .fail_count(fail_count), .busy(busy));

   rll_key_loader #(.MAX_FAIL(1)) dut1 (
      .clk(clk), .rst_n(rst_n1), .load_start(ls1),
      .chunk_valid(cv1), .chunk_data(cd1), .chunk_ready(cr1),
      .check_valid(kv1), .check_data(kd1),
      .key_out(key1), .key_armed(armed1), .lockout(lock1),
      .fail_count(fc1), .busy(busy1));

   function automatic logic [7:0] fold32(input logic [31:0] k);
      return k[31:24] ^ k[23:16] ^ k[15:8] ^ k[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; load_start = 1'b0; chunk_valid = 1'b0; check_valid = 1'b0;
      chunk_data = '0; check_data = '0;
      #3 rst_n = 1'b1;
      m_shadow = '0; m_fail = '0; m_lock = 1'b0;
      tick();
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      m_shadow = '0;
   endtask

   task automatic send(input logic [7:0] d);
      chunk_valid = 1'b1; chunk_data = d;
      #1;
      n_checks++;
      if (chunk_ready !== 1'b1) begin
         n_errors++; $display("FAIL send_ready chunk %h: chunk_ready got %b want 1", d, chunk_ready);
      end
      tick();
      chunk_valid = 1'b0;
      m_shadow = {m_shadow[23:0], d};
   endtask

   task automatic send4(input logic [31:0] k);
      for (int i = 3; i >= 0; i--) send(k[i*8 +: 8]);
   endtask

   task automatic do_check(input string tag, input logic [7:0] c);
      exp_t e, g;
      if (fold32(m_shadow) == c) begin
         e.key = m_shadow; e.armed = 1'b1; m_fail = '0;
      end else begin
         e.key = '0; e.armed = 1'b0; m_fail = m_fail + 1'b1;
         if (m_fail == 2'd3) m_lock = 1'b1;
      end
      e.fail = m_fail; e.lock = m_lock;
      sb.push_back(e);
      check_valid = 1'b1; check_data = c;
      tick();
      check_valid = 1'b0;
      n_checks++;
      if (sb.size() == 0) begin
         n_errors++; $display("FAIL %s scoreboard empty", tag);
      end else begin
         g = sb.pop_front();
         if (key_out !== g.key || key_armed !== g.armed || fail_count !== g.fail || lockout !== g.lock) begin
            n_errors++;
            $display("FAIL %s key/armed/fail/lock got %h/%b/%0d/%b want %h/%b/%0d/%b",
                     tag, key_out, key_armed, fail_count, lockout, g.key, g.armed, g.fail, g.lock);
         end
      end
   endtask

   task automatic test_reset();
      rst_n1 = 1'b0; ls1 = 1'b0; cv1 = 1'b0; kv1 = 1'b0; cd1 = '0; kd1 = '0;
      do_reset();
      rst_n1 = 1'b1;
      n_checks++;
      if ({key_out, key_armed, lockout, fail_count, chunk_ready, busy} !== '0) begin
         n_errors++; $display("FAIL reset key=%h armed=%b lock=%b fail=%0d rdy=%b busy=%b want all 0",
                              key_out, key_armed, lockout, fail_count, chunk_ready, busy);
      end
      n_checks++;
      if ({key1, armed1, lock1, fc1, cr1, busy1} !== '0) begin
         n_errors++; $display("FAIL reset1 key=%h lock=%b fail=%0d want 0", key1, lock1, fc1);
      end
   endtask

   task automatic test_nominal();
      start_load();
      n_checks++;
      if (busy !== 1'b1 || key_out !== 32'h0) begin
         n_errors++; $display("FAIL nominal_busy busy=%b key=%h want 1/0", busy, key_out);
      end
      send4(32'hA5C30F96);
      n_checks++;
      if (chunk_ready !== 1'b0 || key_armed !== 1'b0) begin
         n_errors++; $display("FAIL nominal_ready_drop rdy=%b armed=%b want 0/0", chunk_ready, key_armed);
      end
      do_check("nominal", 8'hFF);
      n_checks++;
      if (key_out !== 32'hA5C30F96) begin
         n_errors++; $display("FAIL nominal_const key got %h want a5c30f96", key_out);
      end
   endtask

   task automatic test_bad_check();
      start_load();
      send4(32'hA5C30F96);
      do_check("bad_check", 8'h00);
      n_checks++;
      if (busy !== 1'b0 || fail_count !== 2'd1) begin
         n_errors++; $display("FAIL bad_idle busy=%b fail=%0d want 0/1", busy, fail_count);
      end
      start_load();
      send4(32'hA5C30F96);
      do_check("bad_reload", 8'hFF);
   endtask

   task automatic test_restart();
      start_load();
      send(8'h11); send(8'h22);
      load_start = 1'b1; chunk_valid = 1'b1; chunk_data = 8'h33;
      #1;
      n_checks++;
      if (chunk_ready !== 1'b0) begin
         n_errors++; $display("FAIL restart_ready got %b want 0", chunk_ready);
      end
      tick();
      load_start = 1'b0; chunk_valid = 1'b0; m_shadow = '0;
      send4(32'hDEADBEEF);
      do_check("restart", 8'h22);
      n_checks++;
      if (key_out !== 32'hDEADBEEF) begin
         n_errors++; $display("FAIL restart_const key got %h want deadbeef", key_out);
      end
   endtask

   task automatic test_gaps();
      logic [31:0] k;
      k = 32'h12345678;
      start_load();
      for (int i = 3; i >= 0; i--) begin
         send(k[i*8 +: 8]);
         if (i != 0) begin
            for (int g = 0; g < 2; g++) begin
               chunk_data = 8'hEE; check_valid = 1'b1; check_data = fold32(k);
               tick();
               check_valid = 1'b0;
            end
         end
      end
      n_checks++;
      if (key_armed !== 1'b0 || busy !== 1'b1 || chunk_ready !== 1'b0) begin
         n_errors++; $display("FAIL gaps_early armed=%b busy=%b rdy=%b want 0/1/0", key_armed, busy, chunk_ready);
      end
      do_check("gaps", 8'h08);
   endtask

   task automatic test_async_reset();
      start_load();
      send4(32'hA5C30F96);
      do_check("pre_async_bad", 8'h5A);
      start_load();
      send(8'hAB); send(8'hCD);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({key_out, key_armed, lockout, fail_count, chunk_ready, busy} !== '0) begin
         n_errors++; $display("FAIL async_reset key=%h armed=%b fail=%0d rdy=%b busy=%b want all 0",
                              key_out, key_armed, fail_count, chunk_ready, busy);
      end
      #2 rst_n = 1'b1;
      m_shadow = '0; m_fail = '0; m_lock = 1'b0;
      tick();
      start_load();
      send4(32'h0BADF00D);
      do_check("async_reload", fold32(32'h0BADF00D));
   endtask

   task automatic test_lockout();
      for (int n = 0; n < 3; n++) begin
         start_load();
         send4(32'hA5C30F96);
         do_check("lockout_bad", 8'h00);
      end
      load_start = 1'b1;
      tick();
      load_start = 1'b0; chunk_valid = 1'b1; chunk_data = 8'hA5;
      #1;
      n_checks++;
      if (chunk_ready !== 1'b0 || busy !== 1'b0) begin
         n_errors++; $display("FAIL lockout_ignore rdy=%b busy=%b want 0/0", chunk_ready, busy);
      end
      tick();
      chunk_valid = 1'b0; check_valid = 1'b1; check_data = 8'hFF;
      tick();
      check_valid = 1'b0;
      n_checks++;
      if (lockout !== 1'b1 || fail_count !== 2'd3 || key_armed !== 1'b0 || key_out !== 32'h0) begin
         n_errors++; $display("FAIL lockout_hold lock=%b fail=%0d armed=%b key=%h want 1/3/0/0",
                              lockout, fail_count, key_armed, key_out);
      end
      do_reset();
      n_checks++;
      if ({key_out, key_armed, lockout, fail_count, busy} !== '0) begin
         n_errors++; $display("FAIL lockout_reset lock=%b fail=%0d want 0/0", lockout, fail_count);
      end
   endtask

   task automatic test_maxfail1();
      logic [31:0] k;
      k = 32'hA5C30F96;
      ls1 = 1'b1; tick(); ls1 = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         cv1 = 1'b1; cd1 = k[i*8 +: 8]; tick();
      end
      cv1 = 1'b0;
      kv1 = 1'b1; kd1 = 8'h00; tick(); kv1 = 1'b0;
      n_checks++;
      if (lock1 !== 1'b1 || fc1 !== 1'b1 || armed1 !== 1'b0 || busy1 !== 1'b0) begin
         n_errors++; $display("FAIL maxfail1 lock=%b fail=%0d armed=%b busy=%b want 1/1/0/0",
                              lock1, fc1, armed1, busy1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_nominal();
      test_bad_check();
      test_restart();
      test_gaps();
      test_async_reset();
      test_lockout();
      test_maxfail1();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/rll_key_loader.md
Name: rll_key_loader

Overview:
- Sequential key-delivery front end for our RLL-locked combinational netlists, which expose a flat key bus of keyIn_* bits.
- Accepts the key as CHUNK_WIDTH-bit chunks over a valid/ready handshake and integrity-checks it with an XOR-fold check word.
- Drives the verified key onto a registered KEY_WIDTH bus feeding the locked core.
- Enforces a sticky lockout after MAX_FAIL consecutive failed commits.

Parameters:
- KEY_WIDTH, 32, width of key bus to locked core; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 8, width of each loaded chunk and of the check word.
- MAX_FAIL, 3, consecutive check failures that force LOCKOUT; minimum 1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse; begins or restarts a key load.
- chunk_valid  in  1  chunk_data valid.
- chunk_data  in  CHUNK_WIDTH  key chunk, most-significant chunk first.
- chunk_ready  out  1  loader accepts a chunk this cycle.
- check_valid  in  1  check_data valid.
- check_data  in  CHUNK_WIDTH  expected XOR-fold of the full key.
- key_out  out  KEY_WIDTH  committed key to locked core (registered).
- key_armed  out  1  key_out holds a verified key.
- lockout  out  1  sticky lockout flag.
- fail_count  out  clog2(MAX_FAIL+1)  consecutive failed commits.
- busy  out  1  high in LOAD or WAIT_CHECK.

Behaviour:
- Reset (async assert, sync release): state=IDLE; key_out=0; key_armed=0; lockout=0; fail_count=0; shadow=0; chunk counter=0; chunk_ready=0; busy=0.
- Derived constant: NCHUNK = KEY_WIDTH/CHUNK_WIDTH.
- States: IDLE, LOAD, WAIT_CHECK, ARMED, LOCKOUT.
- IDLE or ARMED, load_start=1: shadow=0, count=0, key_out=0, key_armed=0; next state LOAD.
- LOAD:
  - chunk_ready = (count<NCHUNK) AND NOT load_start. This is combinational from load_start.
  - Transfer occurs when chunk_valid and chunk_ready are both high.
  - On transfer: shadow <= {shadow[KEY_WIDTH-CHUNK_WIDTH-1:0], chunk_data}; count+1.
  - One chunk per cycle at full rate. Gaps in chunk_valid stall without penalty.
  - When the NCHUNK-th chunk transfers: next state WAIT_CHECK.
- load_start in LOAD or WAIT_CHECK: restart. Clear shadow and count, stay in or return to LOAD. A chunk presented in the same cycle is not accepted. fail_count is unchanged.
- WAIT_CHECK: chunk_ready=0. On check_valid, compute fold = XOR of all NCHUNK chunks of shadow.
  - Match: next cycle key_out=shadow, key_armed=1, fail_count=0, state ARMED. Latency is one cycle from the check_valid edge to key_armed.
  - Mismatch: shadow=0; fail_count+1.
    - If the new fail_count equals MAX_FAIL: state LOCKOUT, lockout=1.
    - Otherwise: state IDLE.
- Ignored inputs:
  - check_valid outside WAIT_CHECK.
  - chunk_valid outside LOAD.
- ARMED: key_out and key_armed are held until load_start or reset.
- LOCKOUT:
  - key_out=0, key_armed=0, chunk_ready=0, busy=0.
  - All inputs ignored; exit only via rst_n.
  - fail_count saturates at MAX_FAIL.
- busy = state is LOAD or WAIT_CHECK.
- Reset mid-load: everything returns to reset values immediately and asynchronously. The partial key is discarded, and nothing partial ever reaches key_out.
- key_out only ever changes to 0 or to a fully verified shadow. It never exposes partial shift contents.

Test Plan:
- Nominal load (defaults): load_start, then chunks A5,C3,0F,96 back-to-back, then check_data=FF -> chunk_ready drops after the 4th chunk; one cycle after check_valid, key_out=0xA5C30F96, key_armed=1, fail_count=0.
- Bad check: same chunks, check_data=00 -> key_armed=0, key_out=0, fail_count=1, state IDLE. Then a correct reload -> armed, fail_count=0.
- Lockout: three consecutive bad checks -> lockout=1 after the 3rd, fail_count=3. A subsequent load_start and chunks are ignored (chunk_ready=0) until rst_n pulses, after which all outputs are 0.
- Restart mid-load: chunks 11,22, then load_start together with chunk 33, then chunks DE,AD,BE,EF, check=22 (DE^AD^BE^EF) -> key_out=0xDEADBEEF; chunk 33 discarded.
- Backpressure/gaps: chunk_valid toggling 1,0,0,1,... plus check_valid asserted during LOAD -> no spurious transfer, early check ignored, final key correct.
- Async reset mid-load: rst_n low after 2 chunks, between clock edges -> outputs 0 immediately. A clean reload afterwards arms correctly; MAX_FAIL=1 build: single bad check -> immediate lockout.
